// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port memory between fetch and load/store ports
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  input  logic [31:0] MemRData,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        MemWrite,
  output logic        IAck,
  output logic        DAck,
  output logic [31:0] IRData,
  output logic [31:0] DRData,
  output logic        Err,
  output logic        Busy,
  output logic [1:0]  ArbState
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state;
  logic grantD, lastD, isWrite;
  logic [2:0] waitCnt;
  logic pickD, reqWrite, reqMis, toResp;
  logic [31:0] reqAddr;
  always_comb begin
    pickD = DReq & (~IReq | ~lastD);
    reqAddr = pickD ? DAddr : IAddr;
    reqWrite = pickD & DWrite;
    reqMis = |reqAddr[1:0];
    toResp = (state == ACCESS && WAIT_CYCLES == 0) || (state == WAIT && waitCnt == 3'd1);
  end
  assign Busy = state != IDLE;
  assign ArbState = state;
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      grantD <= 1'b0;
      lastD <= 1'b1;
      isWrite <= 1'b0;
      waitCnt <= 3'd0;
      MemAddr <= 32'd0;
      MemWData <= 32'd0;
      MemWrite <= 1'b0;
      IAck <= 1'b0;
      DAck <= 1'b0;
      Err <= 1'b0;
      IRData <= 32'd0;
      DRData <= 32'd0;
    end else begin
      MemWrite <= 1'b0;
      IAck <= 1'b0;
      DAck <= 1'b0;
      Err <= 1'b0;
      case (state)
        IDLE: if (IReq | DReq) begin
          grantD <= pickD;
          lastD <= pickD;
          isWrite <= reqWrite;
          if (reqMis) begin
            // misaligned requests skip the memory entirely and respond with Err
            state <= RESP;
            Err <= 1'b1;
            IAck <= ~pickD;
            DAck <= pickD;
          end else begin
            state <= ACCESS;
            MemAddr <= reqAddr;
            MemWData <= DWData;
            MemWrite <= reqWrite;
          end
        end
        ACCESS: begin
          waitCnt <= 3'(WAIT_CYCLES);
          state <= WAIT_CYCLES > 0 ? WAIT : RESP;
        end
        WAIT: begin
          waitCnt <= waitCnt - 3'd1;
          state <= waitCnt == 3'd1 ? RESP : WAIT;
        end
        RESP: state <= IDLE;
      endcase
      if (toResp) begin
        IAck <= ~grantD;
        DAck <= grantD;
        if (!isWrite && grantD) DRData <= MemRData;
        if (!isWrite && !grantD) IRData <= MemRData;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random transactions on three wait-state variants against a transaction-level model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  logic iReq [3], dReq [3], dWrite [3], memWrite [3], iAck [3], dAck [3], err [3], busy [3];
  logic [31:0] iAddr [3], dAddr [3], dWData [3], memRData [3], memAddr [3], memWData [3], iRData [3], dRData [3];
  logic [1:0] arbState [3];
  logic [31:0] mem [64];
  logic [31:0] seedMem [64];
  logic [31:0] refMem [64];
  logic [31:0] expI [3], expD [3];
  bit lastD [3];
  bit memInit;
  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.WAIT_CYCLES(1)) uW1 (.clk(clk), .Reset(resetN), .IReq(iReq[0]), .IAddr(iAddr[0]),
    .DReq(dReq[0]), .DWrite(dWrite[0]), .DAddr(dAddr[0]), .DWData(dWData[0]), .MemRData(memRData[0]),
    .MemAddr(memAddr[0]), .MemWData(memWData[0]), .MemWrite(memWrite[0]), .IAck(iAck[0]), .DAck(dAck[0]),
    .IRData(iRData[0]), .DRData(dRData[0]), .Err(err[0]), .Busy(busy[0]), .ArbState(arbState[0]));
  mem_port_arbiter #(.WAIT_CYCLES(0)) uW0 (.clk(clk), .Reset(resetN), .IReq(iReq[1]), .IAddr(iAddr[1]),
    .DReq(dReq[1]), .DWrite(dWrite[1]), .DAddr(dAddr[1]), .DWData(dWData[1]), .MemRData(memRData[1]),
    .MemAddr(memAddr[1]), .MemWData(memWData[1]), .MemWrite(memWrite[1]), .IAck(iAck[1]), .DAck(dAck[1]),
    .IRData(iRData[1]), .DRData(dRData[1]), .Err(err[1]), .Busy(busy[1]), .ArbState(arbState[1]));
  mem_port_arbiter #(.WAIT_CYCLES(7)) uW7 (.clk(clk), .Reset(resetN), .IReq(iReq[2]), .IAddr(iAddr[2]),
    .DReq(dReq[2]), .DWrite(dWrite[2]), .DAddr(dAddr[2]), .DWData(dWData[2]), .MemRData(memRData[2]),
    .MemAddr(memAddr[2]), .MemWData(memWData[2]), .MemWrite(memWrite[2]), .IAck(iAck[2]), .DAck(dAck[2]),
    .IRData(iRData[2]), .DRData(dRData[2]), .Err(err[2]), .Busy(busy[2]), .ArbState(arbState[2]));

  // shared memory: only one instance is active at a time
  always_comb for (int i = 0; i < 3; i++) memRData[i] = mem[memAddr[i][7:2]];
  always @(posedge clk) begin
    if (!memInit) begin
      if (!resetN) begin
        for (int j = 0; j < 64; j++) mem[j] <= seedMem[j];
        memInit <= 1'b1;
      end
    end else
      for (int i = 0; i < 3; i++) if (memWrite[i]) mem[memAddr[i][7:2]] <= memWData[i];
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int waitOf(int u);
    return u == 0 ? 1 : u == 1 ? 0 : 7;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      expI[i] = 32'd0;
      expD[i] = 32'd0;
      lastD[i] = 1'b1;
    end
  endtask

  task automatic waitIdle(int u);
    int n = 0;
    while (arbState[u] !== 2'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("idle_timeout", arbState[u], 0);
  endtask

  task automatic single(int u, bit port, bit wr, logic [31:0] addr, logic [31:0] data, bit dropEarly);
    int w, k, expLat, wrCycles;
    bit mis, gotAck, storeOk;
    logic [31:0] wrAddr, exState;
    w = waitOf(u);
    mis = addr[1:0] != 2'b00;
    storeOk = port && wr && !mis;
    expLat = mis ? 1 : w + 2;
    wrCycles = 0;
    wrAddr = 0;
    gotAck = 0;
    k = 0;
    waitIdle(u);
    if (port) begin
      dReq[u] = 1; dWrite[u] = wr; dAddr[u] = addr; dWData[u] = data;
    end else begin
      iReq[u] = 1; iAddr[u] = addr;
    end
    while (!gotAck && k < 20) begin
      @(negedge clk);
      k++;
      if (dropEarly) begin iReq[u] = 0; dReq[u] = 0; end
      exState = mis ? 3 : (k == 1) ? 1 : (k <= w + 1) ? 2 : 3;
      check("state", arbState[u], exState);
      if (memWrite[u]) begin wrCycles++; wrAddr = memAddr[u]; end
      gotAck = iAck[u] | dAck[u];
    end
    iReq[u] = 0; dReq[u] = 0; dWrite[u] = 0;
    check("latency", k, expLat);
    check("iack", iAck[u], !port);
    check("dack", dAck[u], port);
    check("err", err[u], mis);
    lastD[u] = port;
    if (storeOk) refMem[addr[7:2]] = data;
    else if (!mis && !(port && wr)) begin
      if (port) expD[u] = refMem[addr[7:2]];
      else expI[u] = refMem[addr[7:2]];
    end
    check("irdata", iRData[u], expI[u]);
    check("drdata", dRData[u], expD[u]);
    check("wr_cycles", wrCycles, storeOk);
    if (storeOk) check("wr_addr", wrAddr, addr);
    @(negedge clk);
    check("idle_after", arbState[u], 0);
    check("ack_low", {iAck[u], dAck[u], err[u]}, 0);
  endtask

  task automatic contend(int u, logic [31:0] ai, logic [31:0] ad);
    int w, k, kI, kD;
    bit firstD;
    w = waitOf(u);
    firstD = !lastD[u];
    k = 0; kI = 0; kD = 0;
    waitIdle(u);
    iReq[u] = 1; iAddr[u] = ai; dReq[u] = 1; dWrite[u] = 0; dAddr[u] = ad;
    while ((kI == 0 || kD == 0) && k < 40) begin
      @(negedge clk);
      k++;
      if (iAck[u]) begin kI = k; iReq[u] = 0; end
      if (dAck[u]) begin kD = k; dReq[u] = 0; end
    end
    iReq[u] = 0; dReq[u] = 0;
    check("first_lat", firstD ? kD : kI, w + 2);
    check("second_gap", firstD ? kI - kD : kD - kI, w + 3);
    lastD[u] = !firstD;
    expI[u] = refMem[ai[7:2]];
    expD[u] = refMem[ad[7:2]];
    check("c_irdata", iRData[u], expI[u]);
    check("c_drdata", dRData[u], expD[u]);
    @(negedge clk);
    check("c_idle_after", arbState[u], 0);
  endtask

  function automatic logic [31:0] alignedAddr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  initial begin
    int acks, u;
    logic [31:0] a;
    resetN = 0;
    for (int i = 0; i < 3; i++) begin
      iReq[i] = 0; dReq[i] = 0; dWrite[i] = 0;
      iAddr[i] = 0; dAddr[i] = 0; dWData[i] = 0;
    end
    for (int j = 0; j < 64; j++) seedMem[j] = $urandom;
    seedMem[4] = 32'hDEADBEEF;
    for (int j = 0; j < 64; j++) refMem[j] = seedMem[j];
    modelReset();
    repeat (2) @(negedge clk);
    resetN = 1;
    for (int i = 0; i < 3; i++) begin
      check("rst_state", arbState[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_outs", {memWrite[i], iAck[i], dAck[i], err[i]}, 0);
      check("rst_irdata", iRData[i], 0);
      check("rst_drdata", dRData[i], 0);
      check("rst_memaddr", memAddr[i], 0);
      check("rst_memwdata", memWData[i], 0);
    end
    contend(0, 32'h40, 32'h44);
    contend(0, 32'h48, 32'h4C);
    single(0, 0, 0, 32'h10, 0, 0);
    check("fetch_deadbeef", iRData[0], 32'hDEADBEEF);
    single(0, 1, 1, 32'h20, 32'h12345678, 0);
    single(0, 1, 0, 32'h20, 0, 0);
    check("load_back", dRData[0], 32'h12345678);
    single(0, 1, 0, 32'h22, 0, 0);
    check("mis_drdata_kept", dRData[0], 32'h12345678);
    single(0, 1, 1, 32'h2B, 32'hCAFEF00D, 0);
    single(1, 0, 0, 32'h10, 0, 0);
    single(2, 0, 0, 32'h10, 0, 0);
    contend(1, 32'h50, 32'h54);
    contend(2, 32'h58, 32'h5C);
    single(2, 1, 1, 32'h80, $urandom, 0);
    single(2, 1, 0, 32'h80, 0, 1);
    single(1, 1, 1, 32'h84, $urandom, 1);
    single(1, 1, 0, 32'h84, 0, 0);
    for (int n = 0; n < 60; n++) begin
      bit p;
      u = $urandom_range(0, 2);
      p = $urandom_range(0, 1) == 1;
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 4) == 0) contend(u, alignedAddr(), alignedAddr());
      else single(u, p, p && ($urandom_range(0, 1) == 1), a, $urandom, $urandom_range(0, 1) == 1);
    end
    // reset during WAIT of a load: aborts without an acknowledge
    waitIdle(0);
    dReq[0] = 1; dWrite[0] = 0; dAddr[0] = 32'h30;
    repeat (2) @(negedge clk);
    check("abort_in_wait", arbState[0], 2);
    #2 resetN = 0;
    #1;
    check("abort_state", arbState[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_dack", dAck[0], 0);
    dReq[0] = 0;
    @(negedge clk);
    resetN = 1;
    modelReset();
    acks = 0;
    repeat (12) begin
      @(negedge clk);
      acks += int'(dAck[0]);
    end
    check("abort_no_dack", acks, 0);
    check("abort_drdata_clr", dRData[0], 0);
    // reset during ACCESS of a store drops MemWrite immediately and leaves memory intact
    waitIdle(0);
    dReq[0] = 1; dWrite[0] = 1; dAddr[0] = 32'h24; dWData[0] = 32'hA5A5_5A5A ^ refMem[9];
    @(negedge clk);
    check("abort_st_memwrite_hi", memWrite[0], 1);
    #2 resetN = 0;
    #1;
    check("abort_st_memwrite_lo", memWrite[0], 0);
    dReq[0] = 0; dWrite[0] = 0;
    @(negedge clk);
    resetN = 1;
    modelReset();
    contend(0, 32'h60, 32'h64);
    single(0, 1, 0, 32'h24, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, memory wait states between address cycle and read-data capture (legal range 0..7).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 IReq  input  1  instruction-fetch request, held high until IAck.
REQ-005 IAddr  input  32  fetch byte address.
REQ-006 DReq  input  1  load/store request, held high until DAck.
REQ-007 DWrite  input  1  1 = store, 0 = load; qualified by DReq.
REQ-008 DAddr  input  32  load/store byte address.
REQ-009 DWData  input  32  store data.
REQ-010 MemRData  input  32  read data from single-port memory.
REQ-011 MemAddr  output  32  address to memory.
REQ-012 MemWData  output  32  write data to memory.
REQ-013 MemWrite  output  1  memory write strobe (1 = WRITE).
REQ-014 IAck / DAck  output  1 each  one-cycle completion pulse per port.
REQ-015 IRData / DRData  output  32 each  last read word delivered to that port.
REQ-016 Err  output  1  misaligned-access flag, valid with the Ack pulse.
REQ-017 Busy  output  1  high whenever state is not IDLE.
REQ-018 ArbState  output  2  current state encoding: IDLE=0, ACCESS=1, WAIT=2, RESP=3.

Function
REQ-019 Requests are sampled only in IDLE; in IDLE with any Req high, the block latches winner, address, DWrite and DWData and moves to ACCESS.
REQ-020 Arbitration: only one Req high -> grant it; both high -> grant the port not granted last (round-robin); LastGrant updates at each grant.
REQ-021 ACCESS (1 cycle): MemAddr = latched address; MemWrite = 1 only for aligned store; wait counter loaded with WAIT_CYCLES; next state WAIT if WAIT_CYCLES > 0, else RESP.
REQ-022 WAIT: counter decrements each cycle; leaves to RESP on the edge where counter equals 1; MemAddr held, MemWrite = 0.
REQ-023 On the edge entering RESP from an aligned load/fetch, MemRData is captured into IRData or DRData of the granted port; the other port's register is unchanged.
REQ-024 RESP (1 cycle): Ack of the granted port = 1, the other Ack = 0; next state IDLE unconditionally.
REQ-025 Latency: sampling edge to Ack-high cycle = WAIT_CYCLES + 2 cycles; back-to-back transactions separated by at least one IDLE cycle.
REQ-026 Stores: DRData unchanged; DAck pulses in RESP as for loads.
REQ-027 Misaligned (address[1:0] != 0): IDLE -> RESP directly, no MemWrite, no data capture, Err = 1 during RESP; Err = 0 otherwise.
REQ-028 Once latched, a transaction completes even if its Req drops; Req changes outside IDLE are ignored.
REQ-029 MemAddr / MemWData hold their last values in IDLE.

Reset
REQ-030 Reset low forces immediately (no clock): state IDLE, MemWrite = 0, IAck = DAck = 0, Err = 0, Busy = 0, ArbState = 0.
REQ-031 Reset low clears MemAddr, MemWData, IRData, DRData and the wait counter to 0 and sets LastGrant = D, so the first contended grant goes to I.
REQ-032 Reset asserted mid-transaction aborts it: no Ack is issued; a store aborted in ACCESS has MemWrite dropped asynchronously.

Verification
REQ-033 WAIT_CYCLES=1, IReq with IAddr=0x10, memory word 0xDEADBEEF -> ArbState 1,2,3; IAck high in cycle 3 after the sampling edge; IRData=0xDEADBEEF.
REQ-034 First cycle after reset, IReq and DReq both high -> I served first, D next (DAck after IAck plus one IDLE cycle); repeat the contention -> I served first again.
REQ-035 Store DAddr=0x20, DWData=0x12345678 -> MemWrite high for exactly one cycle with MemAddr=0x20; a following load from 0x20 -> DRData=0x12345678.
REQ-036 Load DAddr=0x22 -> no MemWrite or capture, DAck and Err both high in the same single cycle, DRData unchanged.
REQ-037 WAIT_CYCLES=0 and WAIT_CYCLES=7 -> Ack at 2 and 9 cycles after the sampling edge respectively.
REQ-038 Reset pulsed low during WAIT of a load -> ArbState=0, Busy=0 immediately, no DAck ever issued for that load.
